// File: rtl/ddr_rdcapture.sv
// DDR read capture: times BL4 reads through a latency shift register, pairs the
// captured beats into burst words and queues them in a small first-in first-out buffer.
module ddr_rdcapture #(
  parameter int BANK_WIDTH = 16,
  parameter int RD_LATENCY = 5,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    rd_cmd,
  input  logic [BANK_WIDTH-1:0]   q0,
  input  logic [BANK_WIDTH-1:0]   q1,
  output logic [4*BANK_WIDTH-1:0] rd_data,
  output logic                    rd_valid,
  input  logic                    rd_ready,
  output logic                    busy,
  output logic                    overflow,
  output logic                    cmd_err
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int WW = 4 * BANK_WIDTH;
  localparam logic [AW:0]   FULL_COUNT = (AW + 1)'(FIFO_DEPTH);
  localparam logic [AW:0]   CNT_ONE    = 1;
  localparam logic [AW-1:0] PTR_ONE    = 1;

  logic [RD_LATENCY-1:0]   pipe;
  logic                    b_pend;
  logic [2*BANK_WIDTH-1:0] pair_a;

  logic [WW-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr, next_rd_ptr;
  logic [AW:0]   count, next_count;
  logic          cmd_ok, pop, push, push_ok;
  logic [WW-1:0] push_word;

  // pipe[0] high means a command was accepted last cycle, so it doubles as the spacing guard
  always_comb begin
    cmd_ok      = rd_cmd & ~pipe[0];
    pop         = rd_valid & rd_ready;
    push        = b_pend;
    push_word   = {q1, q0, pair_a};
    push_ok     = push & ((count != FULL_COUNT) | pop);
    next_rd_ptr = pop ? rd_ptr + PTR_ONE : rd_ptr;
    next_count  = count;
    unique case ({push_ok, pop})
      2'b10:   next_count = count + CNT_ONE;
      2'b01:   next_count = count - CNT_ONE;
      default: next_count = count;
    endcase
  end

  assign busy = (|pipe) | b_pend;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe    <= '0;
      b_pend  <= 1'b0;
      pair_a  <= '0;
      cmd_err <= 1'b0;
    end else begin
      pipe    <= {pipe[RD_LATENCY-2:0], cmd_ok};
      b_pend  <= pipe[RD_LATENCY-1];
      cmd_err <= cmd_err | (rd_cmd & pipe[0]);
      if (pipe[RD_LATENCY-1]) begin
        pair_a <= {q1, q0};
      end
    end
  end

  // The head register is loaded from the word being written when that word becomes the next head
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem[i] <= '0;
      end
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= push_word;
        wr_ptr      <= wr_ptr + PTR_ONE;
      end
      rd_ptr   <= next_rd_ptr;
      count    <= next_count;
      overflow <= overflow | (push & ~push_ok);
      rd_valid <= (next_count != '0);
      if (next_count == '0) begin
        rd_data <= '0;
      end else if (push_ok && (wr_ptr == next_rd_ptr)) begin
        rd_data <= push_word;
      end else begin
        rd_data <= mem[next_rd_ptr];
      end
    end
  end

endmodule

// File: tb/tb_ddr_rdcapture.sv
// Directed bench for ddr_rdcapture: drives reads with planned beats and checks
// delivered words against a queue of expected bursts.
module tb_ddr_rdcapture;

  localparam int BW    = 16;
  localparam int LAT   = 5;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          rd_cmd;
  logic          rd_ready;
  logic [BW-1:0] q0, q1;
  logic [63:0]   rd_data;
  logic          rd_valid, busy, overflow, cmd_err;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  int t0;

  logic [63:0] exp_q [$];
  logic [15:0] plan_q0 [64];
  logic [15:0] plan_q1 [64];
  bit          plan_v  [64];

  logic [63:0] w2 [4] = '{64'hA1A2_A3A4_A5A6_A7A8, 64'hB1B2_B3B4_B5B6_B7B8,
                          64'hC1C2_C3C4_C5C6_C7C8, 64'hD1D2_D3D4_D5D6_D7D8};
  logic [63:0] w4 [5] = '{64'h0101_0202_0303_0404, 64'h1111_1212_1313_1414,
                          64'h2121_2222_2323_2424, 64'h3131_3232_3333_3434,
                          64'h4141_4242_4343_4444};
  logic [63:0] w5 [5] = '{64'h5001_5002_5003_5004, 64'h6001_6002_6003_6004,
                          64'h7001_7002_7003_7004, 64'h8001_8002_8003_8004,
                          64'h9001_9002_9003_9004};

  ddr_rdcapture #(.BANK_WIDTH(BW), .RD_LATENCY(LAT), .FIFO_DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rd_cmd   (rd_cmd),
    .q0       (q0),
    .q1       (q1),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .rd_ready (rd_ready),
    .busy     (busy),
    .overflow (overflow),
    .cmd_err  (cmd_err)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Drives one cycle; beats for a command are scheduled LAT and LAT+1 cycles ahead
  task automatic apply_stimulus(input logic cmd, input logic ready, input logic [63:0] word,
                                input logic beats, input logic keep);
    int a, b;
    rd_cmd   = cmd;
    rd_ready = ready;
    if (beats) begin
      a = (cyc + LAT) & 63;
      b = (cyc + LAT + 1) & 63;
      plan_q0[a] = word[15:0];  plan_q1[a] = word[31:16]; plan_v[a] = 1'b1;
      plan_q0[b] = word[47:32]; plan_q1[b] = word[63:48]; plan_v[b] = 1'b1;
    end
    if (keep) exp_q.push_back(word);
    @(posedge clk);
    #1;
    cyc++;
    rd_cmd = 1'b0;
    a = cyc & 63;
    if (plan_v[a]) begin
      q0 = plan_q0[a];
      q1 = plan_q1[a];
      plan_v[a] = 1'b0;
    end else begin
      q0 = 16'($urandom);
      q1 = 16'($urandom);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1 && rd_valid === 1'b1 && rd_ready === 1'b1) begin
      if (exp_q.size() == 0) check_output("extra_word", 64'(rd_valid), 64'd0);
      else check_output("word_order", rd_data, exp_q.pop_front());
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "[TB] timeout");
  end

  initial begin
    rst_n = 1'b0; rd_cmd = 1'b0; rd_ready = 1'b0; q0 = '0; q1 = '0;
    repeat (2) apply_stimulus(1'b0, 1'b0, 64'd0, 1'b0, 1'b0);
    check_output("reset_valid",    64'(rd_valid), 64'd0);
    check_output("reset_data",     rd_data,       64'd0);
    check_output("reset_busy",     64'(busy),     64'd0);
    check_output("reset_overflow", 64'(overflow), 64'd0);
    check_output("reset_cmd_err",  64'(cmd_err),  64'd0);
    rst_n = 1'b1;

    $display("[TB] single read issued in first cycle after reset release");
    apply_stimulus(1'b1, 1'b1, 64'h4444_3333_2222_1111, 1'b1, 1'b1);
    for (int d = 1; d <= 9; d++) begin
      check_output("single_valid", 64'(rd_valid), 64'(d == 7));
      if (d == 3) check_output("single_busy", 64'(busy), 64'd1);
      apply_stimulus(1'b0, 1'b1, 64'd0, 1'b0, 1'b0);
    end

    $display("[TB] back-to-back reads spaced two cycles");
    t0 = cyc;
    for (int i = 0; i < 16; i++) begin
      logic c;
      int   d;
      c = (i < 8) && (i % 2 == 0);
      apply_stimulus(c, 1'b1, w2[(i / 2) % 4], c, c);
      d = cyc - t0;
      check_output("b2b_valid", 64'(rd_valid),
                   64'(d == 7 || d == 9 || d == 11 || d == 13));
      if (d <= 12) check_output("b2b_busy_high", 64'(busy), 64'd1);
      if (d >= 14) check_output("b2b_busy_low",  64'(busy), 64'd0);
    end
    check_output("b2b_cmd_err", 64'(cmd_err), 64'd0);

    $display("[TB] spacing violation");
    t0 = cyc;
    apply_stimulus(1'b1, 1'b1, 64'hFEED_BEEF_CAFE_F00D, 1'b1, 1'b1);
    check_output("spacing_err_before", 64'(cmd_err), 64'd0);
    apply_stimulus(1'b1, 1'b1, 64'd0, 1'b0, 1'b0);
    for (int d = 2; d <= 10; d++) begin
      check_output("spacing_err_sticky", 64'(cmd_err),  64'd1);
      check_output("spacing_valid",      64'(rd_valid), 64'(d == 7));
      apply_stimulus(1'b0, 1'b1, 64'd0, 1'b0, 1'b0);
    end

    $display("[TB] full buffer with consumer stalled");
    t0 = cyc;
    for (int i = 0; i < 25; i++) begin
      logic c;
      int   d;
      c = (i <= 8) && (i % 2 == 0);
      apply_stimulus(c, i >= 17, w4[(i / 2) % 5], c, c && (i < 8));
      d = cyc - t0;
      check_output("full_valid", 64'(rd_valid), 64'(d >= 7 && d <= 20));
      if (d == 14) check_output("full_overflow_before", 64'(overflow), 64'd0);
      if (d >= 15) check_output("full_overflow_sticky", 64'(overflow), 64'd1);
    end

    rst_n = 1'b0;
    #1;
    check_output("rst_clears_overflow", 64'(overflow), 64'd0);
    check_output("rst_clears_cmd_err",  64'(cmd_err),  64'd0);
    repeat (2) apply_stimulus(1'b0, 1'b0, 64'd0, 1'b0, 1'b0);
    rst_n = 1'b1;

    $display("[TB] push into full buffer with simultaneous pop");
    t0 = cyc;
    for (int i = 0; i < 23; i++) begin
      logic c;
      int   d;
      c = (i <= 8) && (i % 2 == 0);
      apply_stimulus(c, (i == 14) || (i >= 17), w5[(i / 2) % 5], c, c);
      d = cyc - t0;
      check_output("fullpop_valid",    64'(rd_valid), 64'(d >= 7 && d <= 20));
      check_output("fullpop_overflow", 64'(overflow), 64'd0);
    end

    $display("[TB] reset mid-burst");
    t0 = cyc;
    apply_stimulus(1'b1, 1'b1, 64'hDEAD_0001_DEAD_0002, 1'b1, 1'b1);
    repeat (4) apply_stimulus(1'b0, 1'b1, 64'd0, 1'b0, 1'b0);
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check_output("midrst_valid", 64'(rd_valid), 64'd0);
    check_output("midrst_busy",  64'(busy),     64'd0);
    repeat (2) apply_stimulus(1'b0, 1'b1, 64'd0, 1'b0, 1'b0);
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      check_output("postrst_valid", 64'(rd_valid), 64'd0);
      check_output("postrst_busy",  64'(busy),     64'd0);
      apply_stimulus(1'b0, 1'b1, 64'd0, 1'b0, 1'b0);
    end
    apply_stimulus(1'b1, 1'b1, 64'h0BAD_F00D_1234_5678, 1'b1, 1'b1);
    for (int d = 1; d <= 9; d++) begin
      check_output("fresh_valid", 64'(rd_valid), 64'(d == 7));
      apply_stimulus(1'b0, 1'b1, 64'd0, 1'b0, 1'b0);
    end

    check_output("sb_drained", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
